sha256_compress_engine: RTL and testbench

Full SHA-256 compression function for one 512-bit block. Wraps iterated round logic with an on-chip message schedule, round counter, start/done handshake and final chaining addition. Parametrised by rounds unrolled per clock, so the miner can trade area against throughput. Sits between the block/header formatter and the nonce comparator; chaining value is an input so the block serves both the first and second hash of the double-SHA.

---
 rtl/sha256_pkg.sv | 73 +++++++
 rtl/sha256_round.sv | 34 +++
 rtl/sha256_compress_engine.sv | 153 +++++++++++++++
 tb/tb_sha256_compress_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round helper functions for the compression engine.
package sha256_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HASH_W = 256;

    typedef logic [HASH_W-1:0] hash_t;

    // Working variables a..h; a occupies the top word, matching hash packing.
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
        logic [WORD_W-1:0] e;
        logic [WORD_W-1:0] f;
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] h;
    } state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL
    } fsm_e;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [WORD_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] big_s0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] big_s1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] small_s0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] small_s1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e, input logic [WORD_W-1:0] f,
                                             input logic [WORD_W-1:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables in, K and W in, updated variables out.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] st_out
);

    state_t      s;
    state_t      o;
    logic [31:0] t1;
    logic [31:0] t2;

    assign s  = state_t'(st_in);
    assign t1 = s.h + big_s1(s.e) + ch(s.e, s.f, s.g) + k + w;
    assign t2 = big_s0(s.a) + maj(s.a, s.b, s.c);

    always_comb begin
        o   = s;
        o.a = t1 + t2;
        o.b = s.a;
        o.c = s.b;
        o.d = s.c;
        o.e = s.d + t1;
        o.f = s.e;
        o.g = s.f;
        o.h = s.g;
    end

    assign st_out = o;

endmodule

// File: rtl/sha256_compress_engine.sv
// SHA-256 compression of one 512-bit block with RPC rounds per clock, start/done handshake
// and final chaining addition; chaining value is an input so it serves both double-SHA passes.
module sha256_compress_engine
    import sha256_pkg::*;
#(
    parameter int unsigned RPC = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);

    localparam int unsigned NCYC  = 64 / RPC;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned EXT_N = 16 + RPC;

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_rpc_check
        $error("sha256_compress_engine: RPC must be 1, 2, 4 or 8");
    end

    fsm_e             state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    hash_t            vars_q, vars_n;
    hash_t            hsave_q, hsave_n;
    logic [31:0]      win_q [16];
    logic [31:0]      win_n [16];
    logic [31:0]      ext   [EXT_N];
    hash_t            rnd_out;
    hash_t            h_sum;
    hash_t            hash_n;
    logic             busy_n, done_n;

    // Window extended by RPC freshly scheduled words; ext[j] is W for round j of this cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext[i] = win_q[i];
        end
        for (int i = 16; i < int'(EXT_N); i++) begin
            ext[i] = small_s1(ext[i-2]) + ext[i-7] + small_s0(ext[i-15]) + ext[i-16];
        end
    end

    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [255:0] st_i;
        logic [255:0] st_o;
        logic [5:0]   t_idx;
        if (j == 0) begin : g_head
            assign st_i = vars_q;
        end else begin : g_link
            assign st_i = g_rnd[j-1].st_o;
        end
        assign t_idx = 6'(cnt_q * 6'(RPC)) + 6'(j);
        sha256_round u_round (
            .st_in  (st_i),
            .k      (K[t_idx]),
            .w      (ext[j]),
            .st_out (st_o)
        );
    end

    assign rnd_out = g_rnd[RPC-1].st_o;

    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[32*i +: 32] = hsave_q[32*i +: 32] + vars_q[32*i +: 32];
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        vars_n  = vars_q;
        hsave_n = hsave_q;
        win_n   = win_q;
        busy_n  = busy;
        done_n  = 1'b0;
        hash_n  = hash_out;
        case (state_q)
            S_IDLE: begin
                // busy covers the done cycle, so it drops one edge after done
                if (done) begin
                    busy_n = 1'b0;
                end
                if (start && !busy && !abort) begin
                    for (int i = 0; i < 16; i++) begin
                        win_n[i] = block_in[511 - 32*i -: 32];
                    end
                    hsave_n = hash_in;
                    vars_n  = hash_in;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = S_ROUND;
                end
            end
            S_ROUND: begin
                vars_n = rnd_out;
                for (int i = 0; i < 16; i++) begin
                    win_n[i] = ext[i + int'(RPC)];
                end
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCYC - 1)) begin
                    state_n = S_FINAL;
                end
            end
            S_FINAL: begin
                hash_n  = h_sum;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            hash_n  = hash_out;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vars_q   <= '0;
            hsave_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hash_out <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            vars_q   <= vars_n;
            hsave_q  <= hsave_n;
            busy     <= busy_n;
            done     <= done_n;
            hash_out <= hash_n;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_n[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_compress_engine.sv
// Directed-vector bench for sha256_compress_engine: known digests, latency per RPC, handshake corner cases.
module tb_sha256_compress_engine;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_JUNK  = {16{32'hdeadbeef}};
    localparam logic [255:0] H_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start, abort;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         busy, done;
    logic [255:0] hash_out;

    logic         start_m, abort_m;
    logic         busy_m [3];
    logic         done_m [3];
    logic [255:0] hash_m [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sha256_compress_engine #(.RPC(1)) u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .block_in(block_in),
        .hash_in(hash_in), .busy(busy), .done(done), .hash_out(hash_out)
    );
    sha256_compress_engine #(.RPC(2)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .start(start_m), .abort(abort_m), .block_in(block_in),
        .hash_in(hash_in), .busy(busy_m[0]), .done(done_m[0]), .hash_out(hash_m[0])
    );
    sha256_compress_engine #(.RPC(4)) u_dut4 (
        .clk(clk), .n_rst(n_rst), .start(start_m), .abort(abort_m), .block_in(block_in),
        .hash_in(hash_in), .busy(busy_m[1]), .done(done_m[1]), .hash_out(hash_m[1])
    );
    sha256_compress_engine #(.RPC(8)) u_dut8 (
        .clk(clk), .n_rst(n_rst), .start(start_m), .abort(abort_m), .block_in(block_in),
        .hash_in(hash_in), .busy(busy_m[2]), .done(done_m[2]), .hash_out(hash_m[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one job on the RPC=1 instance; lat = edges from accept to done, ndone = pulses seen.
    task automatic run_job(input logic [511:0] blk, input logic [255:0] hv, output int lat, output int ndone);
        block_in = blk;
        hash_in  = hv;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        ndone = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + 2) break;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; start_m = 1'b0; abort_m = 1'b0;
        block_in = '0; hash_in = '0;
        tick(); tick();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_total++; if (hash_out !== 256'h0) $display("FAIL reset_hash got=%h exp=0", hash_out); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (hash_m[k] !== 256'h0 || busy_m[k] !== 1'b0)
                $display("FAIL reset_multi[%0d] hash=%h busy=%b exp=0/0", k, hash_m[k], busy_m[k]);
            else n_pass++;
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_digest(input string name, input logic [511:0] blk, input logic [255:0] exp_h);
        int lat, nd;
        run_job(blk, H_IV, lat, nd);
        n_total++; if (lat !== 65) $display("FAIL %s_latency got=%0d exp=65", name, lat); else n_pass++;
        n_total++; if (nd !== 1) $display("FAIL %s_done_pulses got=%0d exp=1", name, nd); else n_pass++;
        n_total++; if (hash_out !== exp_h) $display("FAIL %s_hash got=%h exp=%h", name, hash_out, exp_h); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL %s_busy_after got=%b exp=0", name, busy); else n_pass++;
    endtask

    task automatic test_rpc_variants();
        logic [511:0] blks  [2] = '{BLK_ABC, BLK_EMPTY};
        logic [255:0] dig   [2] = '{D_ABC, D_EMPTY};
        int           exp_l [3] = '{33, 17, 9};
        int           lat_m [3];
        for (int v = 0; v < 2; v++) begin
            block_in = blks[v];
            hash_in  = H_IV;
            start_m  = 1'b1;
            tick();
            start_m = 1'b0;
            for (int k = 0; k < 3; k++) lat_m[k] = -1;
            for (int n = 1; n <= 45; n++) begin
                tick();
                for (int k = 0; k < 3; k++)
                    if (done_m[k] && lat_m[k] < 0) lat_m[k] = n;
            end
            for (int k = 0; k < 3; k++) begin
                n_total++;
                if (lat_m[k] !== exp_l[k])
                    $display("FAIL rpc_latency[v%0d,i%0d] got=%0d exp=%0d", v, k, lat_m[k], exp_l[k]);
                else n_pass++;
                n_total++;
                if (hash_m[k] !== dig[v])
                    $display("FAIL rpc_hash[v%0d,i%0d] got=%h exp=%h", v, k, hash_m[k], dig[v]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int nd  = 0;
        block_in = BLK_ABC;
        hash_in  = H_IV;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (n == 20) begin block_in = BLK_JUNK; hash_in = '0; start = 1'b1; end
            if (n == 21) start = 1'b0;
            if (n == 40) start = 1'b1;
            if (n == 41) start = 1'b0;
            tick();
            if (done) begin
                nd++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + 2) break;
        end
        n_total++; if (lat !== 65) $display("FAIL busy_start_latency got=%0d exp=65", lat); else n_pass++;
        n_total++; if (nd !== 1) $display("FAIL busy_start_done_pulses got=%0d exp=1", nd); else n_pass++;
        n_total++; if (hash_out !== D_ABC) $display("FAIL busy_start_hash got=%h exp=%h", hash_out, D_ABC); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        int lat2 = -1;
        block_in = BLK_ABC;
        hash_in  = H_IV;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (done) begin lat = n; break; end
        end
        n_total++; if (hash_out !== D_ABC) $display("FAIL b2b_first_hash got=%h exp=%h", hash_out, D_ABC); else n_pass++;
        n_total++; if (busy !== 1'b1 || lat !== 65) $display("FAIL b2b_done_cycle busy=%b lat=%0d exp=1/65", busy, lat); else n_pass++;
        // start raised during the done cycle must not be taken until the following edge
        block_in = BLK_EMPTY;
        start    = 1'b1;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL b2b_done_width got=%b exp=0", done); else n_pass++;
        tick();
        start = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy got=%b exp=1", busy); else n_pass++;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (done) begin lat2 = n; break; end
        end
        n_total++; if (lat2 !== 65) $display("FAIL b2b_second_latency got=%0d exp=65", lat2); else n_pass++;
        n_total++; if (hash_out !== D_EMPTY) $display("FAIL b2b_second_hash got=%h exp=%h", hash_out, D_EMPTY); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_abort();
        int           lat = -1;
        int           nd  = 0;
        logic [255:0] pre = '0;
        abort = 1'b1; start = 1'b1; block_in = BLK_ABC; hash_in = H_IV;
        tick();
        abort = 1'b0; start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_idle_start_busy got=%b exp=0", busy); else n_pass++;
        block_in = BLK_JUNK;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else n_pass++;
        n_total++; if (hash_out !== D_EMPTY) $display("FAIL abort_hash_hold got=%h exp=%h", hash_out, D_EMPTY); else n_pass++;
        block_in = BLK_ABC;
        hash_in  = H_IV;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (lat < 0) pre = hash_out;
            tick();
            if (done) begin
                nd++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + 2) break;
        end
        n_total++; if (lat !== 65) $display("FAIL abort_next_latency got=%0d exp=65", lat); else n_pass++;
        n_total++; if (nd !== 1) $display("FAIL abort_next_done_pulses got=%0d exp=1", nd); else n_pass++;
        n_total++; if (pre !== D_EMPTY) $display("FAIL abort_hash_before_done got=%h exp=%h", pre, D_EMPTY); else n_pass++;
        n_total++; if (hash_out !== D_ABC) $display("FAIL abort_next_hash got=%h exp=%h", hash_out, D_ABC); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, nd;
        block_in = BLK_ABC;
        hash_in  = H_IV;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        #3 n_rst = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else n_pass++;
        n_total++; if (hash_out !== 256'h0) $display("FAIL midrst_hash got=%h exp=0", hash_out); else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        run_job(BLK_ABC, H_IV, lat, nd);
        n_total++; if (lat !== 65) $display("FAIL midrst_next_latency got=%0d exp=65", lat); else n_pass++;
        n_total++; if (hash_out !== D_ABC) $display("FAIL midrst_next_hash got=%h exp=%h", hash_out, D_ABC); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_digest("abc", BLK_ABC, D_ABC);
        test_digest("empty", BLK_EMPTY, D_EMPTY);
        test_rpc_variants();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
